plab4_net_router_input_ctrl_tdm_arb: RTL and testbench
======================================================

PLAB4_NET_ROUTER_INPUT_CTRL_TDM_ARB -- requirements
Module: plab4_net_router_input_ctrl_tdm_arb

Interface
REQ-001 The block SHALL have the parameter p_router_id, default 0: this router's ring index.
REQ-002 The block SHALL have the parameter p_num_routers, default 8: ring size, a power of two and at least 2.
REQ-003 The block SHALL have the parameter p_num_domains, default 2: number of security domains, range 2..8.
REQ-004 The block SHALL have the parameter p_slot_cycles, default 1: length in cycles of one domain slot, at least 1.
REQ-005 The block SHALL have the parameter p_guard_cycles, default 0: dead cycles at the start of each slot, with p_guard_cycles < p_slot_cycles.
REQ-006 The block SHALL have the parameter p_default_reqs, default 3'b001: request vector for a packet whose destination is this router.
REQ-007 The block SHALL derive c_dest_nbits = $clog2(p_num_routers) and c_dom_nbits = max(1, $clog2(p_num_domains)); these are not set externally.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 The block SHALL have port dest, input, p_num_domains*c_dest_nbits bits: per-domain head-flit destination; domain d occupies bits [d*c_dest_nbits +: c_dest_nbits].
REQ-011 The block SHALL have port in_val, input, p_num_domains bits: per-domain input buffer valid.
REQ-012 The block SHALL have port in_rdy, output, p_num_domains bits: per-domain dequeue strobe.
REQ-013 The block SHALL have port reqs, output, 3 bits: requests to output ports {p2,p1,p0}.
REQ-014 The block SHALL have port grants, input, 3 bits: grants from the output-port arbiters.
REQ-015 The block SHALL have port domain, output, c_dom_nbits bits: domain owning the current slot.
REQ-016 The block SHALL have port slot_active, output, 1 bit: high when the current cycle is outside the guard window.
REQ-017 The block SHALL have port slot_start, output, 1 bit: high on the first cycle of every slot.

Function
REQ-018 The block SHALL hold a slot counter cnt ranging 0..p_slot_cycles-1 and a domain register dom ranging 0..p_num_domains-1.
REQ-019 The block SHALL increment cnt each cycle, and when cnt==p_slot_cycles-1 it SHALL set cnt to 0 and advance dom by 1.
REQ-020 dom SHALL wrap from p_num_domains-1 to 0; values >= p_num_domains are never reachable.
REQ-021 Slot rotation SHALL be independent of in_val, grants and traffic (strict TDM, no work-conserving skip), so no cross-domain timing channel exists.
REQ-022 The domain output SHALL equal dom, slot_start SHALL equal (cnt==0), and slot_active SHALL equal (cnt >= p_guard_cycles).
REQ-023 Route computation per domain d: with fd = (dest_d - p_router_id) mod p_num_routers, route_d SHALL be p_default_reqs when fd==0, 3'b100 (p2) when 1 <= fd <= p_num_routers/2, and 3'b001 (p0) otherwise.
REQ-024 reqs SHALL equal route_dom when in_val[dom] and slot_active are both high, and 3'b000 otherwise; requests from non-owning domains are never visible.
REQ-025 in_rdy[d] SHALL be 1 only when d==dom, slot_active is high, in_val[d] is high, and |(route_d & grants) is 1.
REQ-026 Grants received while reqs==0, or for ports not requested, SHALL be ignored.
REQ-027 in_rdy, reqs, domain, slot_active and slot_start SHALL be combinational from registered state plus inputs, with zero-cycle latency from grants to in_rdy.
REQ-028 When p_guard_cycles==0, slot_active SHALL be constant 1.
REQ-029 When p_slot_cycles==1, slot_start SHALL be constant 1 and dom SHALL advance every cycle.

Reset
REQ-030 While reset==0, cnt and dom SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 While reset==0, reqs SHALL be 3'b000, in_rdy SHALL be all zeros, domain SHALL be 0, and slot_active and slot_start SHALL both be 0.
REQ-032 On reset deassertion, the first rising edge after it SHALL begin slot 0 of domain 0 with cnt=0.
REQ-033 Reset asserted mid-slot SHALL abandon the slot without completing it; no in_rdy pulse SHALL occur while reset==0.

Verification
REQ-034 Scenario D=2, S=1, G=0, both in_val=1, grants=3'b111: domain SHALL toggle 0,1,0,1, in_rdy SHALL be 01,10,01,10, and reqs SHALL follow the owning domain's route.
REQ-035 Scenario D=3, S=4, G=1: domain SHALL read 0000 1111 2222 0000, slot_active SHALL read 0111 per slot, slot_start SHALL read 1000 per slot, and no in_rdy SHALL occur in guard cycles.
REQ-036 Scenario id=2, N=8: dest 2 -> reqs=001, dest 3 -> 100, dest 6 -> 100 (tie at fd=4), dest 7 -> 001, dest 1 -> 001.
REQ-037 Scenario: domain 1 requests with in_val[0]=0 while dom=0: reqs SHALL be 000 and in_rdy SHALL be 00 until dom=1.
REQ-038 Scenario: requested port ungranted (reqs=100, grants=011): in_rdy SHALL be 0; then grants=100 in the same cycle: in_rdy of the owner SHALL be 1.
REQ-039 Scenario: reset asserted at cnt=2, dom=1 with no clock edge: domain and all outputs SHALL be 0 at once; after release, rotation SHALL restart at domain 0, cnt 0.

Source files
------------

// File: rtl/plab4_net_router_input_ctrl_tdm_arb.sv
// Ring router input control with strict time-division arbitration between
// security domains: only the slot owner may request or dequeue.
module plab4_net_router_input_ctrl_tdm_arb #(
    parameter int         p_router_id    = 0,
    parameter int         p_num_routers  = 8,
    parameter int         p_num_domains  = 2,
    parameter int         p_slot_cycles  = 1,
    parameter int         p_guard_cycles = 0,
    parameter logic [2:0] p_default_reqs = 3'b001,
    localparam int c_dest_nbits = $clog2(p_num_routers),
    localparam int c_dom_nbits  =
        (p_num_domains > 2) ? $clog2(p_num_domains) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest,
    input  logic [p_num_domains-1:0]              in_val,
    output logic [p_num_domains-1:0]              in_rdy,
    output logic [2:0]                            reqs,
    input  logic [2:0]                            grants,
    output logic [c_dom_nbits-1:0]                domain,
    output logic                                  slot_active,
    output logic                                  slot_start
);

    localparam int c_cnt_nbits =
        (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;

    localparam logic [c_cnt_nbits-1:0]  c_cnt_last =
        c_cnt_nbits'(p_slot_cycles - 1);
    localparam logic [c_dom_nbits-1:0]  c_dom_last =
        c_dom_nbits'(p_num_domains - 1);
    localparam logic [c_dest_nbits-1:0] c_id =
        c_dest_nbits'(p_router_id);
    localparam logic [c_dest_nbits-1:0] c_half =
        c_dest_nbits'(p_num_routers / 2);

    logic [c_cnt_nbits-1:0]  cnt_q, cnt_d;
    logic [c_dom_nbits-1:0]  dom_q, dom_d;
    logic                    act_raw;
    logic [c_dest_nbits-1:0] fd;
    logic [2:0]              route [p_num_domains];

    // Rotation never looks at traffic, so slot timing leaks nothing.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        dom_d = dom_q;
        if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
            dom_d = (dom_q == c_dom_last) ? '0 : dom_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            dom_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dom_q <= dom_d;
        end
    end

    generate
        if (p_guard_cycles == 0) begin : g_no_guard
            assign act_raw = 1'b1;
        end else begin : g_guard
            localparam logic [c_cnt_nbits-1:0] c_guard =
                c_cnt_nbits'(p_guard_cycles);
            assign act_raw = (cnt_q >= c_guard);
        end
    endgenerate

    assign domain      = dom_q;
    assign slot_active = reset & act_raw;
    assign slot_start  = reset & (cnt_q == '0);

    // Forward distance on the ring; ties at half-way go to p2.
    always_comb begin
        fd = '0;
        for (int d = 0; d < p_num_domains; d++) begin
            fd = dest[d*c_dest_nbits +: c_dest_nbits] - c_id;
            if (fd == '0)
                route[d] = p_default_reqs;
            else if (fd <= c_half)
                route[d] = 3'b100;
            else
                route[d] = 3'b001;
        end
    end

    always_comb begin
        reqs   = '0;
        in_rdy = '0;
        for (int d = 0; d < p_num_domains; d++) begin
            if (slot_active && int'(dom_q) == d && in_val[d]) begin
                reqs      = route[d];
                in_rdy[d] = |(route[d] & grants);
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_tdm_arb.sv
// Directed checks of TDM slot rotation, routing and dequeue gating
// on two parameterisations of the input controller.
module tb_plab4_net_router_input_ctrl_tdm_arb;

    logic       clk;
    logic       rst_a, rst_b;

    logic [5:0] dest_a;
    logic [1:0] val_a, rdy_a;
    logic [2:0] reqs_a, gnt_a;
    logic       dom_a, act_a, start_a;

    logic [2:0] db [3];
    logic [8:0] dest_b;
    logic [2:0] val_b, rdy_b;
    logic [2:0] reqs_b, gnt_b;
    logic [1:0] dom_b;
    logic       act_b, start_b;

    int n_chk  = 0;
    int n_pass = 0;

    assign dest_b = {db[2], db[1], db[0]};

    plab4_net_router_input_ctrl_tdm_arb #(
        .p_router_id(0), .p_num_routers(8), .p_num_domains(2),
        .p_slot_cycles(1), .p_guard_cycles(0)
    ) dut_a (
        .clk(clk), .reset(rst_a), .dest(dest_a), .in_val(val_a),
        .in_rdy(rdy_a), .reqs(reqs_a), .grants(gnt_a),
        .domain(dom_a), .slot_active(act_a), .slot_start(start_a)
    );

    plab4_net_router_input_ctrl_tdm_arb #(
        .p_router_id(2), .p_num_routers(8), .p_num_domains(3),
        .p_slot_cycles(4), .p_guard_cycles(1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .dest(dest_b), .in_val(val_b),
        .in_rdy(rdy_b), .reqs(reqs_b), .grants(gnt_b),
        .domain(dom_b), .slot_active(act_b), .slot_start(start_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected per-cycle values for the D=3, S=4, G=1 rotation.
    int         exp_dom [16] = '{0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0};
    logic [2:0] route_b [3]  = '{3'b001, 3'b100, 3'b100};
    logic [2:0] rdy1h   [3]  = '{3'b001, 3'b010, 3'b100};
    logic [2:0] rt_dest [5]  = '{3'd2, 3'd3, 3'd6, 3'd7, 3'd1};
    logic [2:0] rt_exp  [5]  = '{3'b001, 3'b100, 3'b100, 3'b001, 3'b001};

    initial begin
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        dest_a = {3'd7, 3'd1};
        val_a  = 2'b11;
        gnt_a  = 3'b111;
        db[0]  = 3'd2;
        db[1]  = 3'd3;
        db[2]  = 3'd6;
        val_b  = 3'b111;
        gnt_b  = 3'b111;
        #3;
        check("a_rst_reqs",  32'(reqs_a),  32'h0);
        check("a_rst_rdy",   32'(rdy_a),   32'h0);
        check("a_rst_dom",   32'(dom_a),   32'h0);
        check("a_rst_act",   32'(act_a),   32'h0);
        check("a_rst_start", 32'(start_a), 32'h0);
        check("b_rst_reqs",  32'(reqs_b),  32'h0);
        check("b_rst_rdy",   32'(rdy_b),   32'h0);
        check("b_rst_start", 32'(start_b), 32'h0);
        repeat (2) tick();
        check("b_rst_hold_rdy", 32'(rdy_b), 32'h0);

        // D=2, S=1: domain toggles every cycle
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("a_dom",   32'(dom_a),   32'(k % 2));
            check("a_rdy",   32'(rdy_a),   (k % 2 == 0) ? 32'h1 : 32'h2);
            check("a_reqs",  32'(reqs_a),  (k % 2 == 0) ? 32'h4 : 32'h1);
            check("a_start", 32'(start_a), 32'h1);
            check("a_act",   32'(act_a),   32'h1);
            tick();
        end

        // D=3, S=4, G=1 rotation table
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("b_dom",   32'(dom_b),   32'(exp_dom[k]));
            check("b_act",   32'(act_b),   (k % 4 != 0) ? 32'h1 : 32'h0);
            check("b_start", 32'(start_b), (k % 4 == 0) ? 32'h1 : 32'h0);
            check("b_reqs",  32'(reqs_b),
                  (k % 4 != 0) ? 32'(route_b[exp_dom[k]]) : 32'h0);
            check("b_rdy",   32'(rdy_b),
                  (k % 4 != 0) ? 32'(rdy1h[exp_dom[k]]) : 32'h0);
            tick();
        end

        // k=16 dom1 cnt0; k=17 requested port ungranted, then granted
        val_b = 3'b010;
        gnt_b = 3'b011;
        tick();
        check("ungr_reqs", 32'(reqs_b), 32'h4);
        check("ungr_rdy",  32'(rdy_b),  32'h0);
        gnt_b = 3'b100;
        #1;
        check("gr_rdy", 32'(rdy_b), 32'h2);
        check("gr_dom", 32'(dom_b), 32'h1);

        // k=21 dom2 cnt1: route sweep for router id 2
        repeat (4) tick();
        val_b = 3'b100;
        gnt_b = 3'b000;
        for (int i = 0; i < 5; i++) begin
            db[2] = rt_dest[i];
            #1;
            check("route", 32'(reqs_b), 32'(rt_exp[i]));
        end
        check("route_nogrant_rdy", 32'(rdy_b), 32'h0);
        gnt_b = 3'b001;
        #1;
        check("route_grant_rdy", 32'(rdy_b), 32'h4);

        // k=24..27 dom0: domain 1 pending but not owner
        repeat (3) tick();
        val_b = 3'b010;
        gnt_b = 3'b111;
        #1;
        check("iso_dom",   32'(dom_b),  32'h0);
        check("iso_reqs0", 32'(reqs_b), 32'h0);
        tick();
        check("iso_reqs1", 32'(reqs_b), 32'h0);
        check("iso_rdy1",  32'(rdy_b),  32'h0);
        tick();
        check("iso_rdy2",  32'(rdy_b),  32'h0);
        repeat (2) tick();
        check("own_guard_dom",  32'(dom_b),  32'h1);
        check("own_guard_reqs", 32'(reqs_b), 32'h0);
        tick();
        check("own_reqs", 32'(reqs_b), 32'h4);
        check("own_rdy",  32'(rdy_b),  32'h2);

        // k=30 dom1 cnt2: asynchronous reset mid-slot
        tick();
        check("pre_rst_reqs", 32'(reqs_b), 32'h4);
        rst_b = 1'b0;
        #1;
        check("arst_dom",   32'(dom_b),   32'h0);
        check("arst_reqs",  32'(reqs_b),  32'h0);
        check("arst_rdy",   32'(rdy_b),   32'h0);
        check("arst_act",   32'(act_b),   32'h0);
        check("arst_start", 32'(start_b), 32'h0);
        tick();
        check("arst_hold_rdy", 32'(rdy_b), 32'h0);
        check("arst_hold_dom", 32'(dom_b), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("rel_dom",   32'(dom_b),   32'h0);
        check("rel_start", 32'(start_b), 32'h1);
        check("rel_act",   32'(act_b),   32'h0);
        tick();
        check("rel1_dom",   32'(dom_b),   32'h0);
        check("rel1_act",   32'(act_b),   32'h1);
        check("rel1_start", 32'(start_b), 32'h0);
        check("rel1_reqs",  32'(reqs_b),  32'h0);
        repeat (3) tick();
        check("rel4_dom",   32'(dom_b),   32'h1);
        check("rel4_start", 32'(start_b), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
